// File: rtl/fnd_pkg.sv
// Shared FND display package: segment glyphs, digit-enable helpers, field
// widths and the time-field snapshot payload.
//  Glyphs are active-low {dp,g,f,e,d,c,b,a}; digit enables are active-low.
package fnd_pkg;

   localparam int unsigned MSEC_W     = 7;
   localparam int unsigned SEC_W      = 6;
   localparam int unsigned MIN_W      = 6;
   localparam int unsigned HOUR_W     = 5;
   localparam int unsigned FIELD_W    = 7;
   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned SEG_W      = 8;
   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned IDX_W      = 2;
   localparam int unsigned DP_BIT     = 7;

   localparam logic [SEG_W-1:0] SEG_0     = 8'hC0;
   localparam logic [SEG_W-1:0] SEG_1     = 8'hF9;
   localparam logic [SEG_W-1:0] SEG_2     = 8'hA4;
   localparam logic [SEG_W-1:0] SEG_3     = 8'hB0;
   localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
   localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
   localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
   localparam logic [SEG_W-1:0] SEG_7     = 8'hF8;
   localparam logic [SEG_W-1:0] SEG_8     = 8'h80;
   localparam logic [SEG_W-1:0] SEG_9     = 8'h90;
   localparam logic [SEG_W-1:0] SEG_DASH  = 8'hBF;
   localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

   localparam logic [NUM_DIGITS-1:0] DIGIT_NONE    = 4'b1111;
   localparam logic [DIGIT_W-1:0]    CODE_DASH     = 4'hF;
   localparam logic [FIELD_W-1:0]    FIELD_MAX     = 7'd99;
   localparam logic [MSEC_W-1:0]     DP_MSEC_LIMIT = 7'd50;

   // One coherent sample of the displayed time fields
   typedef struct packed {
      logic              sel;
      logic [MSEC_W-1:0] msec;
      logic [SEC_W-1:0]  sec;
      logic [MIN_W-1:0]  min;
      logic [HOUR_W-1:0] hour;
   } time_snap_t;

   typedef struct packed {
      logic [DIGIT_W-1:0] tens;
      logic [DIGIT_W-1:0] ones;
   } digit_pair_t;

   // Active-low one-hot enable for digit position idx
   function automatic logic [NUM_DIGITS-1:0] digit_enable(input logic [IDX_W-1:0] idx);
      return ~(NUM_DIGITS'(1) << idx);
   endfunction

   // Tens/ones split; out-of-range fields map both digits to the dash code
   function automatic digit_pair_t split_field(input logic [FIELD_W-1:0] value);
      digit_pair_t pair;
      if (value > FIELD_MAX) begin
         pair.tens = CODE_DASH;
         pair.ones = CODE_DASH;
      end else begin
         pair.tens = DIGIT_W'(value / FIELD_W'(10));
         pair.ones = DIGIT_W'(value % FIELD_W'(10));
      end
      return pair;
   endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// Combinational BCD digit to active-low 7-segment glyph (dp bit held off).
//  digit  in  4  digit code 0..9; any other code renders a dash
//  seg_c  out 8  {dp,g,f,e,d,c,b,a}, active-low
module fnd_seg_decoder
   import fnd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [SEG_W-1:0]   seg_c
);

   always_comb begin
      seg_c = SEG_DASH;
      case (digit)
         4'd0:    seg_c = SEG_0;
         4'd1:    seg_c = SEG_1;
         4'd2:    seg_c = SEG_2;
         4'd3:    seg_c = SEG_3;
         4'd4:    seg_c = SEG_4;
         4'd5:    seg_c = SEG_5;
         4'd6:    seg_c = SEG_6;
         4'd7:    seg_c = SEG_7;
         4'd8:    seg_c = SEG_8;
         4'd9:    seg_c = SEG_9;
         default: seg_c = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode FND scan controller. Shows sec.msec or hour.min,
// sampled once per frame so a frame never mixes two input samples.
//  clk        in   1  system clock
//  reset      in   1  asynchronous active-low reset
//  sel        in   1  0: sec.msec, 1: hour.min
//  msec       in   7  0..99
//  sec        in   6  0..59
//  min        in   6  0..59
//  hour       in   5  0..23
//  fnd_digit  out  4  active-low digit enables, [0] = rightmost
//  fnd_data   out  8  active-low segments {dp,g,f,e,d,c,b,a}
module fnd_scan_controller
   import fnd_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 100_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sel,
   input  logic [MSEC_W-1:0]     msec,
   input  logic [SEC_W-1:0]      sec,
   input  logic [MIN_W-1:0]      min,
   input  logic [HOUR_W-1:0]     hour,
   output logic [NUM_DIGITS-1:0] fnd_digit,
   output logic [SEG_W-1:0]      fnd_data
);

   localparam int unsigned      CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [IDX_W-1:0] IDX_DP   = IDX_W'(2);

   logic [CNT_W-1:0]   scan_cnt;
   logic [IDX_W-1:0]   idx;
   time_snap_t         snap;
   logic               tick_c;
   logic [FIELD_W-1:0] lo_c;
   logic [FIELD_W-1:0] hi_c;
   digit_pair_t        lo_pair_c;
   digit_pair_t        hi_pair_c;
   logic [DIGIT_W-1:0] digit_c;
   logic [SEG_W-1:0]   glyph_c;
   logic [SEG_W-1:0]   data_c;

   assign tick_c = (scan_cnt == CNT_LAST);

   // Slot timer and digit index
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (tick_c) begin
         scan_cnt <= '0;
         idx      <= idx + IDX_W'(1);
      end else begin
         scan_cnt <= scan_cnt + CNT_W'(1);
      end
   end

   // Sample inputs at the end of the last slot so the next frame is coherent
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snap <= '0;
      end else if (tick_c && (idx == IDX_LAST)) begin
         snap <= {sel, msec, sec, min, hour};
      end
   end

   // Field pair select
   always_comb begin
      lo_c = snap.msec;
      hi_c = FIELD_W'(snap.sec);
      if (snap.sel) begin
         lo_c = FIELD_W'(snap.min);
         hi_c = FIELD_W'(snap.hour);
      end
   end

   assign lo_pair_c = split_field(lo_c);
   assign hi_pair_c = split_field(hi_c);

   // Digit position to BCD code
   always_comb begin
      digit_c = lo_pair_c.ones;
      case (idx)
         2'd0:    digit_c = lo_pair_c.ones;
         2'd1:    digit_c = lo_pair_c.tens;
         2'd2:    digit_c = hi_pair_c.ones;
         default: digit_c = hi_pair_c.tens;
      endcase
   end

   fnd_seg_decoder u_seg_dec (
      .digit (digit_c),
      .seg_c (glyph_c)
   );

   // DP between the two fields blinks at 1 Hz from msec, whichever pair is shown
   always_comb begin
      data_c = glyph_c;
      if ((idx == IDX_DP) && (snap.msec < DP_MSEC_LIMIT)) begin
         data_c[DP_BIT] = 1'b0;
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fnd_digit <= DIGIT_NONE;
         fnd_data  <= SEG_BLANK;
      end else begin
         fnd_digit <= digit_enable(idx);
         fnd_data  <= data_c;
      end
   end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller with SCAN_DIV=4: expected digit slots are
// queued as stimulus is applied and matched as each new slot appears.
module tb_fnd_scan_controller;

   localparam int unsigned SCAN_DIV = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       sel;
   logic [6:0] msec;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic [3:0] fnd_digit;
   logic [7:0] fnd_data;

   typedef struct packed {
      logic [3:0] digit;
      logic [7:0] data;
   } slot_t;

   slot_t      exp_q[$];
   int         n_checks   = 0;
   int         n_fail     = 0;
   bit         mon_en     = 1'b0;
   bit         have_prev  = 1'b0;
   logic [3:0] last_digit = 4'b1111;
   int         slot_cnt   = 0;
   int         slot_no    = 0;

   fnd_scan_controller #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk       (clk),
      .reset     (reset),
      .sel       (sel),
      .msec      (msec),
      .sec       (sec),
      .min       (min),
      .hour      (hour),
      .fnd_digit (fnd_digit),
      .fnd_data  (fnd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] digit, input logic [7:0] data);
      exp_q.push_back({digit, data});
   endtask

   task automatic push_frame(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
      push(4'b1110, d0);
      push(4'b1101, d1);
      push(4'b1011, d2);
      push(4'b0111, d3);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({"drain_", tag}, 12'(exp_q.size()), 12'd0);
      exp_q.delete();
   endtask

   task automatic wait_digit(input logic [3:0] pat, input string tag);
      int n = 0;
      while (fnd_digit !== pat && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({"wait_", tag}, 12'(fnd_digit), 12'(pat));
   endtask

   // Called just after the first post-reset edge, with digit0 already showing
   task automatic arm_monitor();
      last_digit = 4'b1110;
      slot_cnt   = 0;
      have_prev  = 1'b1;
      mon_en     = 1'b1;
   endtask

   // Slot monitor: one-hot-low enables, slot length, slot contents
   initial begin
      slot_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("onehot_low", 12'($countones(~fnd_digit)), 12'd1);
            if (fnd_digit !== last_digit) begin
               if (have_prev) check($sformatf("slot_len_%0d", slot_no), 12'(slot_cnt), 12'd4);
               if (exp_q.size() == 0) begin
                  check("slot_unexpected", 12'(exp_q.size()), 12'd1);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("slot_%0d", slot_no), {fnd_digit, fnd_data}, e);
               end
               slot_no++;
               last_digit = fnd_digit;
               slot_cnt   = 1;
               have_prev  = 1'b1;
            end else begin
               slot_cnt++;
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      sel   = 1'b0;
      msec  = 7'd37;
      sec   = 6'd42;
      min   = 6'd0;
      hour  = 5'd0;

      repeat (3) @(negedge clk);
      check("reset_digit", 12'(fnd_digit), 12'h00F);
      check("reset_data",  12'(fnd_data),  12'h0FF);

      reset = 1'b1;
      @(posedge clk); #1;
      check("first_digit", 12'(fnd_digit), 12'h00E);
      check("first_data",  12'(fnd_data),  12'h0C0);
      arm_monitor();
      // First frame shows the cleared snapshot, then 42.37 for two frames
      push(4'b1101, 8'hC0);
      push(4'b1011, 8'h40);
      push(4'b0111, 8'hC0);
      push_frame(8'hF8, 8'hB0, 8'h24, 8'h99);
      push_frame(8'hF8, 8'hB0, 8'h24, 8'h99);
      wait_drain("sec_msec");

      sel  = 1'b1;
      hour = 5'd23;
      min  = 6'd5;
      msec = 7'd80;
      push_frame(8'h92, 8'hC0, 8'hB0, 8'hA4);
      wait_drain("hour_min");

      sel  = 1'b0;
      msec = 7'd37;
      sec  = 6'd42;
      push_frame(8'hF8, 8'hB0, 8'h24, 8'h99);
      wait_drain("back_sec_msec");

      // sec changes during idx1: rest of frame keeps 42, next frame shows 43
      push_frame(8'hF8, 8'hB0, 8'h24, 8'h99);
      push_frame(8'hF8, 8'hB0, 8'h30, 8'h99);
      wait_digit(4'b1101, "idx1");
      sec = 6'd43;
      wait_drain("no_tear");

      msec = 7'd120;
      push_frame(8'hBF, 8'hBF, 8'hB0, 8'h99);
      wait_drain("illegal_msec");

      // Asynchronous reset in the middle of the idx2 slot
      mon_en = 1'b0;
      wait_digit(4'b1011, "idx2");
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("async_digit", 12'(fnd_digit), 12'h00F);
      check("async_data",  12'(fnd_data),  12'h0FF);
      repeat (2) @(negedge clk);
      check("held_digit", 12'(fnd_digit), 12'h00F);
      check("held_data",  12'(fnd_data),  12'h0FF);

      reset = 1'b1;
      @(posedge clk); #1;
      check("rerelease_digit", 12'(fnd_digit), 12'h00E);
      check("rerelease_data",  12'(fnd_data),  12'h0C0);
      arm_monitor();
      push(4'b1101, 8'hC0);
      push(4'b1011, 8'h40);
      push(4'b0111, 8'hC0);
      push_frame(8'hBF, 8'hBF, 8'hB0, 8'h99);
      wait_drain("post_reset");
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
